register_file_32x32: RTL
========================

// Module: register_file_32x32
// PURPOSE
//   32-entry x 32-bit general-purpose register file for the datapath, with two read ports and one write port.
//   Write-enable select comes from DECODER_5x32 gated by WRITE; each entry is one REG32.
//   Read ports are registered: data appears on the clock edge that samples READ.
//   Feeds ALU operand inputs; written back from ALU/memory result.
// PARAMETERS
//   DATA_WIDTH  32  width of each register and data port
//   ADDR_WIDTH  5   address width; entry count = 2**ADDR_WIDTH = 32
//   ZERO_REG    0   1: entry 0 reads as 0 and writes to it are discarded; 0: entry 0 is ordinary
// PORTS
//   CLK      in   1   clock, rising-edge active
//   RESET    in   1   asynchronous reset, active-low
//   READ     in   1   read strobe, sampled on rising CLK
//   WRITE    in   1   write strobe, sampled on rising CLK
//   ADDR_R1  in   5   read port 1 address
//   ADDR_R2  in   5   read port 2 address
//   ADDR_W   in   5   write address
//   DATA_W   in   32  write data
//   DATA_R1  out  32  registered read data, port 1
//   DATA_R2  out  32  registered read data, port 2
//   R_VALID  out  1   high for exactly the cycle after a read was accepted
// BEHAVIOUR
//   Reset (RESET=0, any time, no CLK needed):
//   - all 32 entries, DATA_R1, DATA_R2 and R_VALID go to 0 immediately.
//   - They stay 0 while RESET=0; no strobe is honoured during reset.
//   Operation is selected by {READ,WRITE} at each rising CLK:
//   - 00 idle: no state change; DATA_R1/R2 hold; R_VALID<=0.
//   - 10 read: DATA_R1<=reg[ADDR_R1], DATA_R2<=reg[ADDR_R2]; R_VALID<=1. Latency 1 edge.
//   - 01 write: reg[ADDR_W]<=DATA_W; DATA_R1/R2 hold; R_VALID<=0.
//   - 11 illegal: treated as idle. No entry written, outputs hold, R_VALID<=0.
//   Read-after-write: a read on the edge after a write to the same address returns the new value.
//     The register file has no write-through bypass, because read and write cannot share an edge.
//   Both read ports may address the same entry; both return the same value.
//   Only the addressed entry changes on a write; all other 31 entries are untouched.
//   ZERO_REG=1:
//   - a write to ADDR_W=0 is discarded.
//   - a read of address 0 returns 32'h0 on either port.
//   Full 32-bit data, no sign handling; addresses 0..31 all valid, no wrap needed.
//   Storage state machine: none beyond per-entry registers plus the output/valid registers.
//   Reset asserted mid-cycle aborts any pending op. The first edge after RESET rises is a normal op edge.
// TESTING
//   1. RESET=0 pulse with no CLK -> DATA_R1=DATA_R2=0, R_VALID=0; a read of any address then returns 0.
//   2. Write 32'hA5A5_0001+i to entry i for i=0..31, then read pairs (i,31-i).
//      Required with ZERO_REG=0: every port returns its written value, R_VALID pulses one cycle per read.
//   3. Write reg5=32'hDEAD_BEEF, then read next edge with ADDR_R1=ADDR_R2=5 -> both ports =32'hDEAD_BEEF.
//   4. Set READ=WRITE=1 with ADDR_W=3, DATA_W=32'h1234. Required: outputs hold, R_VALID=0.
//      A later read of reg3 returns its old value.
//   5. Build with ZERO_REG=1, write 32'hFFFF_FFFF to entry 0, then read (0,0) -> both 32'h0000_0000.
//   6. Write reg7=32'h0000_0077, read reg7, then drop RESET between edges.
//      Required: DATA_R1 clears at once without a CLK; a read of reg7 after RESET=1 returns 0.

Source files
------------

// File: rtl/register_file_32x32.sv
// -----------------------------------------------------------------------------
// register_file_32x32
//   32-entry x 32-bit general-purpose register file: two registered read ports,
//   one write port. The write-enable vector comes from a 5-to-32 decoder gated
//   by WRITE, and each entry is its own 32-bit enable register.
//
// Ports (top):
//   CLK      in   1   rising-edge clock
//   RESET    in   1   asynchronous reset, active-low (clears entries and outputs)
//   READ     in   1   read strobe, sampled on rising CLK
//   WRITE    in   1   write strobe, sampled on rising CLK
//   ADDR_R1  in   5   read port 1 address
//   ADDR_R2  in   5   read port 2 address
//   ADDR_W   in   5   write address
//   DATA_W   in   32  write data
//   DATA_R1  out  32  registered read data, port 1
//   DATA_R2  out  32  registered read data, port 2
//   R_VALID  out  1   high for exactly the cycle after an accepted read
//
// Operation per edge, selected by {READ,WRITE}:
//   10 read, 01 write, 00 idle, 11 treated as idle (nothing written, outputs hold).
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// decoder_5x32
//   One-hot decoder. sel has exactly one bit set (the addressed entry) when
//   en=1, and is all-zero when en=0.
//   Ports: addr (ADDR_WIDTH) in, en (1) in, sel (2**ADDR_WIDTH) out.
// -----------------------------------------------------------------------------
module decoder_5x32 #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic                       en,
  output logic [(2**ADDR_WIDTH)-1:0] sel
);

  localparam int ENTRIES = 2**ADDR_WIDTH;

  // One-hot select of the addressed entry, all-zero when disabled
  always_comb begin
    sel = {ENTRIES{1'b0}};
    if (en) begin
      sel[addr] = 1'b1;
    end else begin
      sel = {ENTRIES{1'b0}};
    end
  end

endmodule

// -----------------------------------------------------------------------------
// reg32
//   Single register-file entry with load enable and asynchronous active-low
//   clear.
//   Ports: clk in, rst_n in, en in, d (DATA_WIDTH) in, q (DATA_WIDTH) out.
// -----------------------------------------------------------------------------
module reg32 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] data_q;

  // Next value: load on enable, otherwise hold
  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end else begin
      data_d = data_q;
    end
  end

  // Entry storage with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// -----------------------------------------------------------------------------
// register_file_32x32 (top)
// -----------------------------------------------------------------------------
module register_file_32x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2,
  output logic                  R_VALID
);

  localparam int ENTRIES = 2**ADDR_WIDTH;

  // Decoded operation for this edge
  logic op_read_s;
  logic op_write_s;

  // Write-enable vector and entry contents
  logic [ENTRIES-1:0]    dec_sel_s;
  logic [ENTRIES-1:0]    entry_we_s;
  logic [DATA_WIDTH-1:0] entry_data_s [ENTRIES];

  // Combinational read mux results
  logic [DATA_WIDTH-1:0] rd1_s;
  logic [DATA_WIDTH-1:0] rd2_s;

  // Output registers
  logic [DATA_WIDTH-1:0] data_r1_d;
  logic [DATA_WIDTH-1:0] data_r1_q;
  logic [DATA_WIDTH-1:0] data_r2_d;
  logic [DATA_WIDTH-1:0] data_r2_q;
  logic                  r_valid_d;
  logic                  r_valid_q;

  // Strobe decode: {READ,WRITE}=11 is illegal and behaves as idle
  always_comb begin
    op_read_s  = 1'b0;
    op_write_s = 1'b0;
    case ({READ, WRITE})
      2'b10: begin
        op_read_s  = 1'b1;
        op_write_s = 1'b0;
      end
      2'b01: begin
        op_read_s  = 1'b0;
        op_write_s = 1'b1;
      end
      default: begin
        op_read_s  = 1'b0;
        op_write_s = 1'b0;
      end
    endcase
  end

  decoder_5x32 #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_dec (
    .addr (ADDR_W),
    .en   (op_write_s),
    .sel  (dec_sel_s)
  );

  // Entry 0 is write-protected when it is the hardwired zero register
  always_comb begin
    entry_we_s = dec_sel_s;
    if (ZERO_REG) begin
      entry_we_s[0] = 1'b0;
    end else begin
      entry_we_s = dec_sel_s;
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    reg32 #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_reg (
      .clk   (CLK),
      .rst_n (RESET),
      .en    (entry_we_s[g]),
      .d     (DATA_W),
      .q     (entry_data_s[g])
    );
  end

  // Read muxes; address 0 is forced to zero when it is the zero register
  always_comb begin
    rd1_s = entry_data_s[ADDR_R1];
    rd2_s = entry_data_s[ADDR_R2];
    if (ZERO_REG && (ADDR_R1 == {ADDR_WIDTH{1'b0}})) begin
      rd1_s = {DATA_WIDTH{1'b0}};
    end else begin
      rd1_s = entry_data_s[ADDR_R1];
    end
    if (ZERO_REG && (ADDR_R2 == {ADDR_WIDTH{1'b0}})) begin
      rd2_s = {DATA_WIDTH{1'b0}};
    end else begin
      rd2_s = entry_data_s[ADDR_R2];
    end
  end

  // Output next-state: capture on read, otherwise hold; valid only after a read
  always_comb begin
    data_r1_d = data_r1_q;
    data_r2_d = data_r2_q;
    r_valid_d = 1'b0;
    if (op_read_s) begin
      data_r1_d = rd1_s;
      data_r2_d = rd2_s;
      r_valid_d = 1'b1;
    end else begin
      data_r1_d = data_r1_q;
      data_r2_d = data_r2_q;
      r_valid_d = 1'b0;
    end
  end

  // Output registers with asynchronous clear
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data_r1_q <= {DATA_WIDTH{1'b0}};
      data_r2_q <= {DATA_WIDTH{1'b0}};
      r_valid_q <= 1'b0;
    end else begin
      data_r1_q <= data_r1_d;
      data_r2_q <= data_r2_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign DATA_R1 = data_r1_q;
  assign DATA_R2 = data_r2_q;
  assign R_VALID = r_valid_q;

endmodule
